// File: rtl/pc_unit.sv
// Fetch-stage program counter with relative branch, stall and a circular return-address stack.
// Optional target alignment check (adds output misalign) is enabled by defining PC_ALIGN_CHK_EN.
module pc_unit #(
  parameter int unsigned WIDTH     = 32,
  parameter logic [31:0] RESET_VEC = 32'h0100_0000,
  parameter int unsigned STEP      = 4,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             stall,
  input  logic                             ld,
  input  logic                             ret,
  input  logic                             call,
  input  logic                             br,
  input  logic                             inc,
  input  logic [WIDTH-1:0]                 d,
  input  logic [WIDTH-1:0]                 off,
  output logic [WIDTH-1:0]                 q,
  output logic [$clog2(RAS_DEPTH+1)-1:0]   ras_cnt,
  output logic                             ras_ovf,
  output logic                             ras_unf
`ifdef PC_ALIGN_CHK_EN
  ,
  output logic                             misalign
`endif
);

  localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);
  localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
`ifdef PC_ALIGN_CHK_EN
  localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(STEP - 1);
`endif

  logic [WIDTH-1:0] ras [RAS_DEPTH];
  logic [PTR_W-1:0] wr_ptr, wr_inc, wr_dec, wr_nx;
  logic [WIDTH-1:0] seq, tgt, q_nx;
  logic [CNT_W-1:0] cnt_nx;
  logic             take, push, pop, ovf_nx, unf_nx, full, empty;
`ifdef PC_ALIGN_CHK_EN
  logic             mis_nx;
`endif

  // wr_ptr names the next free slot; when full it also names the oldest entry
  assign wr_inc = (wr_ptr == PTR_W'(RAS_DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
  assign wr_dec = (wr_ptr == '0) ? PTR_W'(RAS_DEPTH - 1) : wr_ptr - PTR_W'(1);
  assign seq    = q + WIDTH'(STEP);
  assign full   = (ras_cnt == CNT_W'(RAS_DEPTH));
  assign empty  = (ras_cnt == '0);

  // Priority decode: stall > ld > ret > call > br > inc
  always_comb begin
    q_nx   = q;
    cnt_nx = ras_cnt;
    wr_nx  = wr_ptr;
    tgt    = q;
    take   = 1'b0;
    push   = 1'b0;
    pop    = 1'b0;
    ovf_nx = 1'b0;
    unf_nx = 1'b0;
`ifdef PC_ALIGN_CHK_EN
    mis_nx = 1'b0;
`endif
    if (stall) begin
      take = 1'b0;
    end else if (ld) begin
      tgt  = d;
      take = 1'b1;
    end else if (ret) begin
      if (empty) begin
        unf_nx = 1'b1;
      end else begin
        tgt  = ras[wr_dec];
        take = 1'b1;
        pop  = 1'b1;
      end
    end else if (call) begin
      tgt  = d;
      take = 1'b1;
      push = 1'b1;
    end else if (br) begin
      tgt  = q + off;
      take = 1'b1;
    end else if (inc) begin
      q_nx = seq;
    end
`ifdef PC_ALIGN_CHK_EN
    // A misaligned target is dropped entirely, including its stack effect
    if (take && ((tgt & ALIGN_MASK) != '0)) begin
      mis_nx = 1'b1;
      take   = 1'b0;
      push   = 1'b0;
      pop    = 1'b0;
    end
`endif
    if (take) q_nx = tgt;
    if (push) begin
      wr_nx = wr_inc;
      if (full) ovf_nx = 1'b1;
      else      cnt_nx = ras_cnt + CNT_W'(1);
    end
    if (pop) begin
      wr_nx  = wr_dec;
      cnt_nx = ras_cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q       <= WIDTH'(RESET_VEC);
      ras_cnt <= '0;
      wr_ptr  <= '0;
      ras_ovf <= 1'b0;
      ras_unf <= 1'b0;
      for (int i = 0; i < int'(RAS_DEPTH); i++) ras[i] <= '0;
    end else begin
      q       <= q_nx;
      ras_cnt <= cnt_nx;
      wr_ptr  <= wr_nx;
      ras_ovf <= ovf_nx;
      ras_unf <= unf_nx;
      if (push) ras[wr_ptr] <= seq;
    end
  end

`ifdef PC_ALIGN_CHK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) misalign <= 1'b0;
    else        misalign <= mis_nx;
  end
`endif

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit (default parameters, alignment check disabled).
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        rst_n, stall, ld, ret, call, br, inc;
  logic [31:0] d, off, q;
  logic [2:0]  ras_cnt;
  logic        ras_ovf, ras_unf;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  typedef struct {
    int          cyc;
    logic [31:0] q;
    logic [2:0]  cnt;
    logic        ovf;
    logic        unf;
  } exp_t;

  exp_t sb[$];

  pc_unit dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .ld(ld), .ret(ret), .call(call),
    .br(br), .inc(inc), .d(d), .off(off), .q(q), .ras_cnt(ras_cnt),
    .ras_ovf(ras_ovf), .ras_unf(ras_unf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Monitor: every result becomes observable at the negedge following its posedge
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      if (e.cyc < cyc) begin
        chk("missed_slot", 32'(cyc), 32'(e.cyc));
      end else begin
        chk("q", q, e.q);
        chk("ras_cnt", 32'(ras_cnt), 32'(e.cnt));
        chk("ras_ovf", 32'(ras_ovf), 32'(e.ovf));
        chk("ras_unf", 32'(ras_unf), 32'(e.unf));
      end
    end
  end

  // Present one control vector for one cycle and queue the state expected after the edge
  task automatic drv(input logic s, input logic l, input logic r, input logic c,
                     input logic b, input logic i, input logic [31:0] dv, input logic [31:0] ov,
                     input logic [31:0] eq, input int ecnt, input logic eo, input logic eu);
    exp_t e;
    @(negedge clk);
    {stall, ld, ret, call, br, inc} = {s, l, r, c, b, i};
    d   = dv;
    off = ov;
    e.cyc = cyc + 1;
    e.q   = eq;
    e.cnt = 3'(ecnt);
    e.ovf = eo;
    e.unf = eu;
    sb.push_back(e);
  endtask

  task automatic idle_ctl();
    {stall, ld, ret, call, br, inc} = '0;
    d   = '0;
    off = '0;
  endtask

  initial begin
    rst_n = 1'b1;
    idle_ctl();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_q", q, 32'h0100_0000);
    chk("rst_cnt", 32'(ras_cnt), 32'd0);
    chk("rst_ovf", 32'(ras_ovf), 32'd0);
    chk("rst_unf", 32'(ras_unf), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    //   stall ld ret call br inc  d              off            exp q          cnt ovf unf
    drv(0, 0, 0, 0, 0, 1, 32'h0,         32'h0,         32'h0100_0004, 0, 0, 0);
    drv(0, 0, 0, 0, 0, 1, 32'h0,         32'h0,         32'h0100_0008, 0, 0, 0);
    drv(0, 0, 0, 0, 0, 1, 32'h0,         32'h0,         32'h0100_000C, 0, 0, 0);
    drv(0, 1, 0, 0, 0, 0, 32'h100,       32'h0,         32'h100,       0, 0, 0);
    drv(1, 1, 0, 0, 0, 1, 32'h999,       32'h0,         32'h100,       0, 0, 0);
    drv(0, 1, 0, 0, 0, 1, 32'h2000,      32'h0,         32'h2000,      0, 0, 0);
    drv(0, 0, 0, 0, 1, 0, 32'h0,         32'hFFFF_FFF0, 32'h1FF0,      0, 0, 0);
    drv(0, 0, 0, 0, 0, 0, 32'h0,         32'h0,         32'h1FF0,      0, 0, 0);
    // nested call/return
    drv(0, 1, 0, 0, 0, 0, 32'h100,       32'h0,         32'h100,       0, 0, 0);
    drv(0, 0, 0, 1, 0, 0, 32'h400,       32'h0,         32'h400,       1, 0, 0);
    drv(0, 0, 0, 1, 0, 0, 32'h800,       32'h0,         32'h800,       2, 0, 0);
    drv(0, 0, 1, 0, 0, 0, 32'h0,         32'h0,         32'h404,       1, 0, 0);
    drv(0, 0, 1, 0, 0, 0, 32'h0,         32'h0,         32'h104,       0, 0, 0);
    // overflow: fifth call overwrites the oldest entry (0x14)
    drv(0, 1, 0, 0, 0, 0, 32'h10,        32'h0,         32'h10,        0, 0, 0);
    drv(0, 0, 0, 1, 0, 0, 32'h20,        32'h0,         32'h20,        1, 0, 0);
    drv(0, 0, 0, 1, 0, 0, 32'h30,        32'h0,         32'h30,        2, 0, 0);
    drv(0, 0, 0, 1, 0, 0, 32'h40,        32'h0,         32'h40,        3, 0, 0);
    drv(0, 0, 0, 1, 0, 0, 32'h50,        32'h0,         32'h50,        4, 0, 0);
    drv(0, 0, 0, 1, 0, 0, 32'h60,        32'h0,         32'h60,        4, 1, 0);
    drv(0, 0, 0, 0, 0, 0, 32'h0,         32'h0,         32'h60,        4, 0, 0);
    drv(0, 0, 1, 0, 0, 0, 32'h0,         32'h0,         32'h54,        3, 0, 0);
    drv(0, 0, 1, 0, 0, 0, 32'h0,         32'h0,         32'h44,        2, 0, 0);
    drv(0, 0, 1, 0, 0, 0, 32'h0,         32'h0,         32'h34,        1, 0, 0);
    drv(0, 0, 1, 0, 0, 0, 32'h0,         32'h0,         32'h24,        0, 0, 0);
    // underflow, stall masking, ret beating call
    drv(0, 1, 0, 0, 0, 0, 32'h300,       32'h0,         32'h300,       0, 0, 0);
    drv(0, 0, 1, 0, 0, 0, 32'h0,         32'h0,         32'h300,       0, 0, 1);
    drv(0, 0, 0, 0, 0, 0, 32'h0,         32'h0,         32'h300,       0, 0, 0);
    drv(1, 0, 1, 0, 0, 0, 32'h0,         32'h0,         32'h300,       0, 0, 0);
    drv(0, 0, 1, 1, 0, 0, 32'h500,       32'h0,         32'h300,       0, 0, 1);
    // wrap-around
    drv(0, 1, 0, 0, 0, 0, 32'hFFFF_FFFC, 32'h0,         32'hFFFF_FFFC, 0, 0, 0);
    drv(0, 0, 0, 0, 0, 1, 32'h0,         32'h0,         32'h0,         0, 0, 0);
    // priority ret > call > br > inc
    drv(0, 0, 0, 1, 0, 0, 32'h500,       32'h0,         32'h500,       1, 0, 0);
    drv(0, 0, 1, 1, 1, 1, 32'h900,       32'h40,        32'h4,         0, 0, 0);
    drv(0, 0, 0, 1, 1, 1, 32'h700,       32'h40,        32'h700,       1, 0, 0);
    drv(0, 0, 0, 0, 1, 1, 32'h0,         32'h10,        32'h710,       1, 0, 0);
    drv(0, 0, 0, 0, 0, 0, 32'h0,         32'h0,         32'h710,       1, 0, 0);

    // drain scoreboard before the asynchronous reset
    for (int k = 0; k < 4 && sb.size() > 0; k++) @(negedge clk);
    chk("sb_drain", 32'(sb.size()), 32'd0);
    sb.delete();

    // reset during a pending call must discard it and clear the stack
    call = 1'b1;
    d    = 32'h900;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_q", q, 32'h0100_0000);
    chk("mid_rst_cnt", 32'(ras_cnt), 32'd0);
    @(negedge clk);
    chk("held_rst_q", q, 32'h0100_0000);
    idle_ctl();
    rst_n = 1'b1;
    drv(0, 0, 1, 0, 0, 0, 32'h0,         32'h0,         32'h0100_0000, 0, 0, 1);
    drv(0, 0, 0, 0, 0, 0, 32'h0,         32'h0,         32'h0100_0000, 0, 0, 0);

    for (int k = 0; k < 4 && sb.size() > 0; k++) @(negedge clk);
    chk("sb_final", 32'(sb.size()), 32'd0);
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
